// File: rtl/surf_cin_transmitter_pkg.sv
// Shared types and constants for the SURF command-input (CIN) transmitter.
package surf_cin_pkg;

   typedef enum logic [1:0] {
      WAIT_SYNC = 2'd0,
      TRAIN     = 2'd1,
      RUN       = 2'd2
   } cin_state_t;

   localparam int unsigned NIBBLES_PER_WORD = 8;
   localparam int unsigned CIN_WORD_WIDTH   = 32;
   localparam int unsigned NIBBLE_WIDTH     = 4;
   localparam int unsigned PHASE_WIDTH      = 3;
   localparam int unsigned COUNT_WIDTH      = 16;

   localparam logic [CIN_WORD_WIDTH-1:0] IDLE_WORD  = 32'h0;
   localparam logic [PHASE_WIDTH-1:0]    LAST_PHASE = PHASE_WIDTH'(NIBBLES_PER_WORD - 1);

endpackage : surf_cin_pkg

// File: rtl/surf_cin_transmitter_if.sv
// Command/CIN bundle between a command source and the CIN transmitter.
interface surf_cin_transmitter_if;
   import surf_cin_pkg::*;

   logic                      sync;
   logic                      train_enable;
   logic [CIN_WORD_WIDTH-1:0] cmd_data;
   logic                      cmd_valid;
   logic                      cmd_ready;
   logic [NIBBLE_WIDTH-1:0]   cin;
   logic                      running;
   logic                      sync_realign;
   logic [COUNT_WIDTH-1:0]    cmd_count;

   // Command source / frame controller side
   modport master (
      output sync, train_enable, cmd_data, cmd_valid,
      input  cmd_ready, cin, running, sync_realign, cmd_count
   );

   // Transmitter side
   modport slave (
      input  sync, train_enable, cmd_data, cmd_valid,
      output cmd_ready, cin, running, sync_realign, cmd_count
   );

endinterface : surf_cin_transmitter_if

// File: rtl/surf_cin_transmitter.sv
// Serialises 32-bit command words into 4-bit nibbles (MSB first) for the SURF
// CIN OSERDES, framed by sync_i, with a training pattern mode.
module surf_cin_transmitter
   import surf_cin_pkg::*;
#(
   parameter logic                      CIN_INV       = 1'b0,
   parameter logic [CIN_WORD_WIDTH-1:0] TRAIN_PATTERN = 32'hA55A6996
) (
   input  logic                      sysclk_i,
   input  logic                      rst_i,
   input  logic                      sync_i,
   input  logic                      train_enable_i,
   input  logic [CIN_WORD_WIDTH-1:0] cmd_data_i,
   input  logic                      cmd_valid_i,
   output logic                      cmd_ready_o,
   output logic [NIBBLE_WIDTH-1:0]   cin_o,
   output logic                      running_o,
   output logic                      sync_realign_o,
   output logic [COUNT_WIDTH-1:0]    cmd_count_o
);

   cin_state_t                r_state;
   cin_state_t                w_state_nxt;
   logic [PHASE_WIDTH-1:0]    r_p;
   logic [PHASE_WIDTH-1:0]    w_p_nxt;
   logic [CIN_WORD_WIDTH-1:0] r_sr;
   logic [CIN_WORD_WIDTH-1:0] w_sr_nxt;
   logic                      r_realign;
   logic [COUNT_WIDTH-1:0]    r_count;
   logic                      w_load;
   logic                      w_ready;
   logic                      w_realign;
   logic                      w_accept;

   // State register
   always_ff @(posedge sysclk_i) begin
      if (rst_i) begin
         r_state <= WAIT_SYNC;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state, word framing and shift-register update
   always_comb begin
      w_state_nxt = r_state;
      w_p_nxt     = r_p;
      w_sr_nxt    = r_sr;
      w_ready     = 1'b0;
      w_load      = ((r_p == LAST_PHASE) || sync_i) && ((r_state != WAIT_SYNC) || sync_i);

      case (r_state)
         WAIT_SYNC: begin
            if (sync_i) begin
               w_state_nxt = train_enable_i ? TRAIN : RUN;
            end
         end
         TRAIN, RUN: begin
            if (w_load) begin
               w_state_nxt = train_enable_i ? TRAIN : RUN;
            end
         end
         default: w_state_nxt = WAIT_SYNC;
      endcase

      if (w_load) begin
         w_p_nxt = '0;
         if (w_state_nxt == TRAIN) begin
            w_sr_nxt = TRAIN_PATTERN;
         end else begin
            w_sr_nxt = cmd_valid_i ? cmd_data_i : IDLE_WORD;
            w_ready  = 1'b1;
         end
      end else if (r_state == WAIT_SYNC) begin
         w_p_nxt  = '0;
         w_sr_nxt = '0;
      end else begin
         w_p_nxt  = PHASE_WIDTH'(r_p + PHASE_WIDTH'(1));
         w_sr_nxt = {r_sr[CIN_WORD_WIDTH-NIBBLE_WIDTH-1:0], {NIBBLE_WIDTH{1'b0}}};
      end
   end

   // A sync that lands mid-word while framed truncates the word in flight
   assign w_realign = sync_i && (r_state != WAIT_SYNC) && (r_p != LAST_PHASE);
   assign w_accept  = w_ready && cmd_valid_i;

   // Datapath registers: phase, shift register, realign pulse, accept counter
   always_ff @(posedge sysclk_i) begin
      if (rst_i) begin
         r_p       <= '0;
         r_sr      <= '0;
         r_realign <= 1'b0;
         r_count   <= '0;
      end else begin
         r_p       <= w_p_nxt;
         r_sr      <= w_sr_nxt;
         r_realign <= w_realign;
         if (w_accept) begin
            r_count <= COUNT_WIDTH'(r_count + COUNT_WIDTH'(1));
         end
      end
   end

   assign cmd_ready_o    = w_ready;
   assign cin_o          = r_sr[CIN_WORD_WIDTH-1 -: NIBBLE_WIDTH] ^ {NIBBLE_WIDTH{CIN_INV}};
   assign running_o      = (r_state == RUN);
   assign sync_realign_o = r_realign;
   assign cmd_count_o    = r_count;

endmodule : surf_cin_transmitter

// File: tb/tb_surf_cin_transmitter.sv
// Directed self-checking bench for surf_cin_transmitter (normal and inverted CIN).
module tb_surf_cin_transmitter;
   import surf_cin_pkg::*;

   logic sysclk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   logic [3:0]  inv_cin;
   logic        inv_ready;
   logic        inv_running;
   logic        inv_realign;
   logic [15:0] inv_count;

   surf_cin_transmitter_if bus ();

   always #5 sysclk = ~sysclk;

   surf_cin_transmitter #(.CIN_INV(1'b0)) dut (
      .sysclk_i       (sysclk),
      .rst_i          (rst),
      .sync_i         (bus.sync),
      .train_enable_i (bus.train_enable),
      .cmd_data_i     (bus.cmd_data),
      .cmd_valid_i    (bus.cmd_valid),
      .cmd_ready_o    (bus.cmd_ready),
      .cin_o          (bus.cin),
      .running_o      (bus.running),
      .sync_realign_o (bus.sync_realign),
      .cmd_count_o    (bus.cmd_count)
   );

   surf_cin_transmitter #(.CIN_INV(1'b1)) dut_inv (
      .sysclk_i       (sysclk),
      .rst_i          (rst),
      .sync_i         (bus.sync),
      .train_enable_i (bus.train_enable),
      .cmd_data_i     (bus.cmd_data),
      .cmd_valid_i    (bus.cmd_valid),
      .cmd_ready_o    (inv_ready),
      .cin_o          (inv_cin),
      .running_o      (inv_running),
      .sync_realign_o (inv_realign),
      .cmd_count_o    (inv_count)
   );

   // Advance to just after the next rising edge
   task automatic step();
      @(posedge sysclk);
      #1;
   endtask

   function automatic logic [3:0] nib(input logic [31:0] w, input int k);
      logic [31:0] t;
      t = w >> (28 - 4 * k);
      return t[3:0];
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      bus.sync = 1'b0; bus.train_enable = 1'b0; bus.cmd_valid = 1'b0; bus.cmd_data = 32'h0;
      step(); step();
      rst = 1'b0;
      #1;
      checks++; if (bus.cin !== 4'h0) begin errors++; $display("FAIL reset_cin got %h want 0", bus.cin); end
      checks++; if (inv_cin !== 4'hF) begin errors++; $display("FAIL reset_inv_cin got %h want f", inv_cin); end
      checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", bus.cmd_ready); end
      checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL reset_running got %b want 0", bus.running); end
      checks++; if (bus.sync_realign !== 1'b0) begin errors++; $display("FAIL reset_realign got %b want 0", bus.sync_realign); end
      checks++; if (bus.cmd_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.cmd_count); end
      // Waiting for the first sync: nothing moves
      for (int i = 0; i < 4; i++) begin
         step();
         checks++; if (bus.cin !== 4'h0 || bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL wait_sync_idle cyc %0d cin %h ready %b want 0 0", i, bus.cin, bus.cmd_ready); end
      end
   endtask

   task automatic test_run_word();
      logic [31:0] w;
      w = 32'h12345678;
      bus.sync = 1'b1; bus.train_enable = 1'b0; bus.cmd_valid = 1'b1; bus.cmd_data = w;
      #1;
      checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL first_sync_ready got %b want 1", bus.cmd_ready); end
      step();
      bus.sync = 1'b0;
      checks++; if (bus.sync_realign !== 1'b0) begin errors++; $display("FAIL first_sync_realign got %b want 0", bus.sync_realign); end
      checks++; if (bus.running !== 1'b1) begin errors++; $display("FAIL run_running got %b want 1", bus.running); end
      checks++; if (bus.cmd_count !== 16'd1) begin errors++; $display("FAIL run_count got %0d want 1", bus.cmd_count); end
      // New data offered mid-word must not disturb the word in flight
      bus.cmd_data = 32'hFFFF_FFFF;
      for (int k = 0; k < 8; k++) begin
         if (k == 4) bus.cmd_valid = 1'b0;
         #1;
         checks++; if (bus.cin !== nib(w, k)) begin errors++; $display("FAIL run_nibble %0d got %h want %h", k, bus.cin, nib(w, k)); end
         checks++; if (inv_cin !== 4'(~nib(w, k))) begin errors++; $display("FAIL inv_nibble %0d got %h want %h", k, inv_cin, 4'(~nib(w, k))); end
         if (k < 7) begin
            checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL midword_ready %0d got %b want 0", k, bus.cmd_ready); end
         end
         step();
      end
      checks++; if (bus.cmd_count !== 16'd1) begin errors++; $display("FAIL run_count_after got %0d want 1", bus.cmd_count); end
   endtask

   task automatic test_idle_and_back_to_back();
      logic [31:0] words [3];
      int n;
      words[0] = 32'h9ABCDEF0; words[1] = 32'h13579BDF; words[2] = 32'h2468ACE0;
      for (int i = 0; i < 16; i++) begin
         checks++; if (bus.cin !== 4'h0) begin errors++; $display("FAIL idle_cin %0d got %h want 0", i, bus.cin); end
         checks++; if (inv_cin !== 4'hF) begin errors++; $display("FAIL idle_inv_cin %0d got %h want f", i, inv_cin); end
         step();
      end
      checks++; if (bus.cmd_count !== 16'd1) begin errors++; $display("FAIL idle_count got %0d want 1", bus.cmd_count); end
      bus.cmd_valid = 1'b1; bus.cmd_data = words[0];
      n = 0;
      #1;
      while (bus.cmd_ready !== 1'b1 && n < 16) begin step(); n++; end
      checks++; if (n >= 16) begin errors++; $display("FAIL b2b_wait_ready timeout got %0d cycles want <16", n); end
      step();
      for (int w = 0; w < 3; w++) begin
         if (w < 2) bus.cmd_data = words[w + 1];
         else bus.cmd_valid = 1'b0;
         for (int k = 0; k < 8; k++) begin
            #1;
            checks++; if (bus.cin !== nib(words[w], k)) begin errors++; $display("FAIL b2b_word %0d nibble %0d got %h want %h", w, k, bus.cin, nib(words[w], k)); end
            step();
         end
      end
      checks++; if (bus.cmd_count !== 16'd4) begin errors++; $display("FAIL b2b_count got %0d want 4", bus.cmd_count); end
   endtask

   task automatic test_realign();
      logic [31:0] w_old, w_new;
      int n;
      w_old = 32'hCAFEBABE; w_new = 32'h71E2D3C4;
      bus.cmd_valid = 1'b1; bus.cmd_data = w_old;
      n = 0;
      #1;
      while (bus.cmd_ready !== 1'b1 && n < 16) begin step(); n++; end
      checks++; if (n >= 16) begin errors++; $display("FAIL realign_wait_ready timeout got %0d cycles want <16", n); end
      step();
      bus.cmd_valid = 1'b0;
      for (int k = 0; k < 3; k++) step();
      checks++; if (bus.cin !== nib(w_old, 3)) begin errors++; $display("FAIL realign_old_p3 got %h want %h", bus.cin, nib(w_old, 3)); end
      bus.sync = 1'b1; bus.cmd_valid = 1'b1; bus.cmd_data = w_new;
      #1;
      checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL realign_ready got %b want 1", bus.cmd_ready); end
      step();
      bus.sync = 1'b0; bus.cmd_valid = 1'b0;
      checks++; if (bus.sync_realign !== 1'b1) begin errors++; $display("FAIL realign_pulse got %b want 1", bus.sync_realign); end
      checks++; if (inv_realign !== 1'b1) begin errors++; $display("FAIL realign_pulse_inv got %b want 1", inv_realign); end
      for (int k = 0; k < 8; k++) begin
         checks++; if (bus.cin !== nib(w_new, k)) begin errors++; $display("FAIL realign_new nibble %0d got %h want %h", k, bus.cin, nib(w_new, k)); end
         if (k > 0) begin
            checks++; if (bus.sync_realign !== 1'b0) begin errors++; $display("FAIL realign_once %0d got %b want 0", k, bus.sync_realign); end
         end
         step();
      end
      checks++; if (bus.cmd_count !== 16'd6) begin errors++; $display("FAIL realign_count got %0d want 6", bus.cmd_count); end
   endtask

   task automatic test_train();
      logic [31:0] pat;
      pat = 32'hA55A6996;
      for (int k = 0; k < 7; k++) step();
      bus.sync = 1'b1; bus.train_enable = 1'b1;
      #1;
      checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL train_entry_ready got %b want 0", bus.cmd_ready); end
      step();
      for (int w = 0; w < 3; w++) begin
         for (int k = 0; k < 8; k++) begin
            bus.sync = (k == 7);
            #1;
            checks++; if (bus.cin !== nib(pat, k)) begin errors++; $display("FAIL train_word %0d nibble %0d got %h want %h", w, k, bus.cin, nib(pat, k)); end
            checks++; if (bus.cmd_ready !== 1'b0 || bus.sync_realign !== 1'b0 || bus.running !== 1'b0) begin
               errors++; $display("FAIL train_flags %0d.%0d ready %b realign %b running %b want 0 0 0", w, k, bus.cmd_ready, bus.sync_realign, bus.running);
            end
            step();
         end
      end
      bus.sync = 1'b0;
      checks++; if (bus.cmd_count !== 16'd6) begin errors++; $display("FAIL train_count got %0d want 6", bus.cmd_count); end
   endtask

   task automatic test_reset_midword();
      logic [31:0] w, w2;
      int n;
      w = 32'h89ABCDEF; w2 = 32'h5A5A0F0F;
      bus.train_enable = 1'b0; bus.cmd_valid = 1'b1; bus.cmd_data = w;
      n = 0;
      #1;
      while (bus.cmd_ready !== 1'b1 && n < 16) begin step(); n++; end
      checks++; if (n >= 16) begin errors++; $display("FAIL rstmid_wait_ready timeout got %0d cycles want <16", n); end
      step();
      bus.cmd_valid = 1'b0;
      checks++; if (bus.running !== 1'b1 || bus.cin !== 4'h8) begin errors++; $display("FAIL train_to_run running %b cin %h want 1 8", bus.running, bus.cin); end
      for (int k = 0; k < 4; k++) step();
      checks++; if (bus.cin !== 4'hC || bus.cmd_count !== 16'd7) begin errors++; $display("FAIL rstmid_p4 cin %h count %0d want c 7", bus.cin, bus.cmd_count); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++; if (bus.cin !== 4'h0 || inv_cin !== 4'hF) begin errors++; $display("FAIL rstmid_cin got %h/%h want 0/f", bus.cin, inv_cin); end
      checks++; if (bus.running !== 1'b0 || bus.sync_realign !== 1'b0 || bus.cmd_count !== 16'd0) begin
         errors++; $display("FAIL rstmid_outputs running %b realign %b count %0d want 0 0 0", bus.running, bus.sync_realign, bus.cmd_count);
      end
      bus.cmd_valid = 1'b1; bus.cmd_data = 32'hDEADBEEF;
      for (int i = 0; i < 12; i++) begin
         #1;
         checks++; if (bus.cin !== 4'h0 || bus.cmd_ready !== 1'b0 || bus.running !== 1'b0 || bus.cmd_count !== 16'd0) begin
            errors++; $display("FAIL rstmid_quiet %0d cin %h ready %b running %b count %0d want 0 0 0 0", i, bus.cin, bus.cmd_ready, bus.running, bus.cmd_count);
         end
         step();
      end
      bus.sync = 1'b1; bus.cmd_data = w2;
      #1;
      checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rstmid_resync_ready got %b want 1", bus.cmd_ready); end
      step();
      bus.sync = 1'b0; bus.cmd_valid = 1'b0;
      checks++; if (bus.sync_realign !== 1'b0) begin errors++; $display("FAIL rstmid_resync_realign got %b want 0", bus.sync_realign); end
      checks++; if (bus.cmd_count !== 16'd1) begin errors++; $display("FAIL rstmid_resync_count got %0d want 1", bus.cmd_count); end
      checks++; if (bus.cin !== 4'h5 || inv_cin !== 4'hA) begin errors++; $display("FAIL rstmid_resync_cin got %h/%h want 5/a", bus.cin, inv_cin); end
      step();
      checks++; if (bus.cin !== 4'hA) begin errors++; $display("FAIL rstmid_resync_n1 got %h want a", bus.cin); end
   endtask

   initial begin
      test_reset();
      test_run_word();
      test_idle_and_back_to_back();
      test_realign();
      test_train();
      test_reset_midword();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_surf_cin_transmitter

// File: doc/surf_cin_transmitter.md
SURF_CIN_TRANSMITTER -- requirements
Module: surf_cin_transmitter

Interface
REQ-001 SHALL have parameter CIN_INV, default 1'b0: when 1, every bit of cin_o is inverted, including the reset value.
REQ-002 SHALL have parameter TRAIN_PATTERN, default 32'hA55A6996: the word sent repeatedly in TRAIN state.
REQ-003 SHALL have port sysclk_i, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port sync_i, input, 1 bit: single-cycle frame marker; the cycle after it carries nibble 0.
REQ-006 SHALL have port train_enable_i, input, 1 bit: 1 selects TRAIN, 0 selects RUN.
REQ-007 SHALL have port cmd_data_i, input, 32 bits: command word to send to the SURF.
REQ-008 SHALL have port cmd_valid_i, input, 1 bit: cmd_data_i is valid.
REQ-009 SHALL have port cmd_ready_o, output, 1 bit: a word is accepted on any edge where cmd_valid_i and cmd_ready_o are both 1.
REQ-010 SHALL have port cin_o, output, 4 bits: registered nibble to the OSERDES PHY, MSB first.
REQ-011 SHALL have port running_o, output, 1 bit: 1 while in RUN state.
REQ-012 SHALL have port sync_realign_o, output, 1 bit: one-cycle pulse when a sync arrives off frame.
REQ-013 SHALL have port cmd_count_o, output, 16 bits: count of accepted command words, wraps modulo 2^16.

Function
REQ-014 SHALL keep a 3-bit phase counter p and a 32-bit shift register sr; cin_o SHALL equal sr[31:28] XOR {4{CIN_INV}}.
REQ-015 SHALL define a load edge as any edge where (p==7) or sync_i is 1, and the state is not WAIT_SYNC or a sync is present.
- On a load edge: p SHALL be set to 0 and sr SHALL be loaded.
- On any other edge: p SHALL be incremented (wrapping 7->0) and sr SHALL be shifted left by 4, with zero fill.
REQ-016 SHALL use three states, WAIT_SYNC, TRAIN and RUN, with these transitions:
- WAIT_SYNC -> TRAIN or RUN on the first sync_i, chosen by train_enable_i.
- TRAIN <-> RUN only on load edges, following train_enable_i.
REQ-017 SHALL, in WAIT_SYNC, hold sr at 0, hold p at 0, and drive cmd_ready_o to 0.
REQ-018 SHALL, on a load edge entering or staying in TRAIN, load sr with TRAIN_PATTERN; cmd_ready_o SHALL be 0.
REQ-019 SHALL, on a load edge entering or staying in RUN, load sr with cmd_data_i if cmd_valid_i is 1, else with the idle word 32'h0.
REQ-020 SHALL drive cmd_ready_o combinationally as 1 exactly when the current edge is a load edge and the next state is RUN.
REQ-021 SHALL have latency from accept edge to first nibble on cin_o of 1 cycle; the word SHALL span 8 consecutive cycles, nibble k = word[31-4k -: 4].
REQ-022 SHALL, when sync_i=1 with p!=7 in TRAIN or RUN, pulse sync_realign_o for one cycle; the partially sent word SHALL be truncated and not resent.
REQ-023 SHALL NOT pulse sync_realign_o for a sync with p==7, nor for the first sync out of WAIT_SYNC.
REQ-024 SHALL increment cmd_count_o by 1 per accept and wrap from 16'hFFFF to 0.
REQ-025 SHALL, when cmd_valid_i drops mid-word, leave the word in flight unaffected, since data is captured only at the accept edge.

Reset
REQ-026 SHALL, on rst_i=1 at an edge, set:
- state to WAIT_SYNC;
- p and sr to 0;
- cin_o to {4{CIN_INV}};
- cmd_ready_o, running_o, sync_realign_o and cmd_count_o to 0.
REQ-027 SHALL give rst_i priority over sync_i on the same edge; a reset mid-word SHALL discard the word, and it SHALL NOT be counted again.

Structure
REQ-028 SHALL put the following in package surf_cin_pkg: the state enum (WAIT_SYNC, TRAIN, RUN), NIBBLES_PER_WORD=8, IDLE_WORD=32'h0 and CIN_WORD_WIDTH=32.
REQ-029 SHALL be one flat module with no sub-module; OSERDES/ODELAY instantiation SHALL live in a sibling surf_cin_phy and not in this block.

Verification
REQ-030 SHALL cover: reset, then sync_i at cycle 5 with RUN and cmd_valid_i=1, data=32'h12345678 -> accept at cycle 5, cin_o = 1,2,3,4,5,6,7,8 on cycles 6-13, cmd_count_o=1.
REQ-031 SHALL cover: train_enable_i=1 with syncs every 8 cycles -> cin_o repeats A,5,5,A,6,9,9,6, cmd_ready_o never 1, sync_realign_o never 1.
REQ-032 SHALL cover: in RUN, a sync at p=3 -> sync_realign_o pulses once, cin_o shows the new word's nibble 0 the next cycle, and the old word is truncated.
REQ-033 SHALL cover: in RUN with cmd_valid_i=0 -> cin_o=0 continuously, cmd_count_o unchanged; then valid for 3 back-to-back words -> 24 contiguous nibbles, count +3.
REQ-034 SHALL cover: CIN_INV=1 with reset -> cin_o=4'hF; idle word sent as 4'hF nibbles; data 32'h12345678 -> E,D,C,B,A,9,8,7.
REQ-035 SHALL cover: rst_i asserted at p=4 of a word -> next cycle all outputs at reset values, and no output activity until the next sync_i.
